tracesys_capture_writer: RTL and testbench

Capture write controller that accepts an Avalon-ST sample stream and writes it into the capture data RAM through that RAM's write port (wr_address/wr_writedata/wr_write/wr_waitrequest). It holds the RAM as a circular pre-trigger buffer while armed. On trigger it records the trigger location and captures a programmed number of post-trigger samples, then stops. It sits directly upstream of the capture data RAM; software and readout logic use its status outputs to locate the trace.

---
 rtl/tracesys_capture_writer.sv | 158 +++++++++++++++
 tb/tb_tracesys_capture_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tracesys_capture_writer.sv
// tracesys_capture_writer
// Streams Avalon-ST samples into the capture data RAM write port. While armed
// the RAM is a circular pre-trigger buffer; a trigger records its address and
// a clamped number of post-trigger samples is captured before stopping.
// Optional feature macro: TRACESYS_CAPTURE_SOP_TRIGGER_EN makes an accepted
// start-of-packet beat act as a trigger as well.
module tracesys_capture_writer #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 1,
   parameter int DEPTH         = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_WIDTH-1:0]    in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_startofpacket,
   input  logic                     arm,
   input  logic                     trigger,
   input  logic [ADDRESS_WIDTH:0]   post_count,
   output logic [ADDRESS_WIDTH-1:0] wr_address,
   output logic [DATA_WIDTH-1:0]    wr_writedata,
   output logic                     wr_write,
   input  logic                     wr_waitrequest,
   output logic                     busy,
   output logic                     done,
   output logic                     wrapped,
   output logic [ADDRESS_WIDTH-1:0] trig_address,
   output logic [ADDRESS_WIDTH:0]   sample_count
);

   localparam int CW = ADDRESS_WIDTH + 1;
   localparam logic [CW-1:0]            DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0]            POST_MAX  = CW'(DEPTH - 1);
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

`ifdef TRACESYS_CAPTURE_SOP_TRIGGER_EN
   localparam logic SOP_TRIG_EN = 1'b1;
`else
   localparam logic SOP_TRIG_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_POST,
      S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]            post_left_q, post_left_d;
   logic [ADDRESS_WIDTH-1:0] trig_address_q, trig_address_d;
   logic [CW-1:0]            sample_count_q, sample_count_d;
   logic                     wrapped_q, wrapped_d;
   logic                     done_q, done_d;

   logic acc;
   logic trig_hit;
   logic ptr_last;

   // Zero-latency accept and RAM write path
   always_comb begin
      in_ready     = ((state_q == S_ARMED) || (state_q == S_POST)) && !wr_waitrequest;
      acc          = in_valid && in_ready;
      wr_write     = acc;
      wr_writedata = in_data;
      wr_address   = wr_ptr_q;
      trig_hit     = trigger || (SOP_TRIG_EN && in_startofpacket);
      ptr_last     = (wr_ptr_q == LAST_ADDR);
      busy         = (state_q == S_ARMED) || (state_q == S_POST);
      done         = done_q;
      wrapped      = wrapped_q;
      trig_address = trig_address_q;
      sample_count = sample_count_q;
   end

   // Next-state, pointer and status computation
   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      post_left_d    = post_left_q;
      trig_address_d = trig_address_q;
      sample_count_d = sample_count_q;
      wrapped_d      = wrapped_q;
      done_d         = done_q;

      if (acc) begin
         wr_ptr_d = ptr_last ? '0 : wr_ptr_q + ADDRESS_WIDTH'(1);
         if (sample_count_q != DEPTH_C) begin
            sample_count_d = sample_count_q + CW'(1);
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            // No beats are accepted here, so arm owns every register.
            if (arm) begin
               state_d        = S_ARMED;
               wr_ptr_d       = '0;
               sample_count_d = '0;
               wrapped_d      = 1'b0;
               done_d         = 1'b0;
               // Clamp so the post-trigger run can never lap the trigger beat.
               post_left_d    = (post_count > POST_MAX) ? POST_MAX : post_count;
            end
         end
         S_ARMED: begin
            if (acc) begin
               if (ptr_last) begin
                  wrapped_d = 1'b1;
               end
               if (trig_hit) begin
                  trig_address_d = wr_ptr_q;
                  if (post_left_q == '0) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_POST;
                  end
               end
            end
         end
         S_POST: begin
            if (acc) begin
               post_left_d = post_left_q - CW'(1);
               if (post_left_q == CW'(1)) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and status registers, asynchronously cleared
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         wr_ptr_q       <= '0;
         post_left_q    <= '0;
         trig_address_q <= '0;
         sample_count_q <= '0;
         wrapped_q      <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         post_left_q    <= post_left_d;
         trig_address_q <= trig_address_d;
         sample_count_q <= sample_count_d;
         wrapped_q      <= wrapped_d;
         done_q         <= done_d;
      end
   end

endmodule

// File: tb/tb_tracesys_capture_writer.sv
// Directed self-checking bench for tracesys_capture_writer (DEPTH=4).
module tb_tracesys_capture_writer;

   localparam int DW = 8;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          in_startofpacket;
   logic          arm;
   logic          trigger;
   logic [AW:0]   post_count;
   logic [AW-1:0] wr_address;
   logic [DW-1:0] wr_writedata;
   logic          wr_write;
   logic          wr_waitrequest;
   logic          busy;
   logic          done;
   logic          wrapped;
   logic [AW-1:0] trig_address;
   logic [AW:0]   sample_count;

   int checks = 0;
   int errors = 0;

   // Observed RAM contents and write history
   logic [DW-1:0] mem [4];
   logic [AW-1:0] addr_log [64];
   int            wcnt = 0;

   logic [AW-1:0] exp_addr [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

   tracesys_capture_writer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .in_startofpacket(in_startofpacket), .arm(arm),
      .trigger(trigger), .post_count(post_count), .wr_address(wr_address),
      .wr_writedata(wr_writedata), .wr_write(wr_write),
      .wr_waitrequest(wr_waitrequest), .busy(busy), .done(done),
      .wrapped(wrapped), .trig_address(trig_address), .sample_count(sample_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wr_write) begin
         mem[wr_address]  <= wr_writedata;
         addr_log[wcnt]   <= wr_address;
         wcnt             <= wcnt + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm(input logic [AW:0] pc);
      arm = 1'b1;
      post_count = pc;
      step();
      arm = 1'b0;
   endtask

   task automatic test_reset();
      int base;
      reset = 1'b1; wr_waitrequest = 1'b1; in_valid = 1'b0; in_data = '0;
      in_startofpacket = 1'b0; arm = 1'b0; trigger = 1'b0; post_count = '0;
      step(); step();
      checks++; if ({busy, done, wrapped, in_ready, wr_write} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b want 00000", {busy, done, wrapped, in_ready, wr_write}); end
      checks++; if (trig_address !== 2'd0 || sample_count !== 3'd0) begin errors++; $display("FAIL rst_regs got trig=%0d cnt=%0d want 0 0", trig_address, sample_count); end
      reset = 1'b0;
      base = wcnt;
      in_valid = 1'b1; trigger = 1'b1; in_data = 8'hA5;
      do_arm(3'd0);
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || wr_write !== 1'b0) begin errors++; $display("FAIL wait_block got busy=%b rdy=%b wr=%b want 1 0 0", busy, in_ready, wr_write); end
      step();
      checks++; if (in_ready !== 1'b0 || sample_count !== 3'd0) begin errors++; $display("FAIL wait_hold got rdy=%b cnt=%0d want 0 0", in_ready, sample_count); end
      wr_waitrequest = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1 || wr_write !== 1'b1 || wr_address !== 2'd0 || wr_writedata !== 8'hA5) begin errors++; $display("FAIL first_beat got rdy=%b wr=%b a=%0d d=%h want 1 1 0 a5", in_ready, wr_write, wr_address, wr_writedata); end
      step();
      in_valid = 1'b0; trigger = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || trig_address !== 2'd0 || sample_count !== 3'd1) begin errors++; $display("FAIL post0_done got done=%b busy=%b rdy=%b trig=%0d cnt=%0d want 1 0 0 0 1", done, busy, in_ready, trig_address, sample_count); end
      step();
      checks++; if (wcnt - base !== 1) begin errors++; $display("FAIL post0_writes got %0d want 1", wcnt - base); end
   endtask

   task automatic test_wrap();
      int base;
      base = wcnt;
      do_arm(3'd2);
      checks++; if (done !== 1'b0 || busy !== 1'b1 || sample_count !== 3'd0 || wrapped !== 1'b0) begin errors++; $display("FAIL rearm got done=%b busy=%b cnt=%0d wrap=%b want 0 1 0 0", done, busy, sample_count, wrapped); end
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; in_data = 8'h10 + 8'(i); trigger = (i == 5);
         #1;
         checks++; if (in_ready !== (i < 8)) begin errors++; $display("FAIL wrap_ready beat %0d got %b want %b", i, in_ready, (i < 8)); end
         step();
      end
      in_valid = 1'b0; trigger = 1'b0;
      step();
      checks++; if (wcnt - base !== 8) begin errors++; $display("FAIL wrap_writes got %0d want 8", wcnt - base); end
      for (int k = 0; k < 8; k++) begin
         checks++; if (addr_log[base + k] !== exp_addr[k]) begin errors++; $display("FAIL wrap_addr %0d got %0d want %0d", k, addr_log[base + k], exp_addr[k]); end
      end
      checks++; if (wrapped !== 1'b1 || trig_address !== 2'd1 || sample_count !== 3'd4 || done !== 1'b1) begin errors++; $display("FAIL wrap_status got wrap=%b trig=%0d cnt=%0d done=%b want 1 1 4 1", wrapped, trig_address, sample_count, done); end
      checks++; if (mem[1] !== 8'h15) begin errors++; $display("FAIL wrap_trigdata got %h want 15", mem[1]); end
   endtask

   task automatic test_clamp();
      int base;
      base = wcnt;
      do_arm(3'd7);
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = 8'hC0 + 8'(i); trigger = (i == 0);
         step();
      end
      in_valid = 1'b0; trigger = 1'b0;
      step();
      checks++; if (wcnt - base !== 4) begin errors++; $display("FAIL clamp_writes got %0d want 4", wcnt - base); end
      checks++; if (mem[0] !== 8'hC0 || trig_address !== 2'd0) begin errors++; $display("FAIL clamp_trig got d=%h trig=%0d want c0 0", mem[0], trig_address); end
      checks++; if (done !== 1'b1 || wrapped !== 1'b0 || sample_count !== 3'd4) begin errors++; $display("FAIL clamp_status got done=%b wrap=%b cnt=%0d want 1 0 4", done, wrapped, sample_count); end
   endtask

   task automatic test_waitrequest();
      int base;
      base = wcnt;
      do_arm(3'd3);
      in_valid = 1'b1; trigger = 1'b1; in_data = 8'h70;
      step();
      trigger = 1'b0;
      wr_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'h71 + 8'(i);
         #1;
         checks++; if (in_ready !== 1'b0 || wr_write !== 1'b0) begin errors++; $display("FAIL wait_post %0d got rdy=%b wr=%b want 0 0", i, in_ready, wr_write); end
         step();
      end
      checks++; if (busy !== 1'b1 || done !== 1'b0 || sample_count !== 3'd1) begin errors++; $display("FAIL wait_state got busy=%b done=%b cnt=%0d want 1 0 1", busy, done, sample_count); end
      wr_waitrequest = 1'b0;
      step(); step();
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wait_early got done=%b busy=%b want 0 1", done, busy); end
      step();
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wait_final got done=%b busy=%b want 1 0", done, busy); end
      in_valid = 1'b0;
      step();
      checks++; if (wcnt - base !== 4) begin errors++; $display("FAIL wait_writes got %0d want 4", wcnt - base); end
   endtask

   task automatic test_reset_mid();
      int base;
      do_arm(3'd3);
      in_valid = 1'b1; trigger = 1'b0; in_data = 8'h40;
      step();
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      step();
      checks++; if (busy !== 1'b1 || trig_address !== 2'd1) begin errors++; $display("FAIL mid_pre got busy=%b trig=%0d want 1 1", busy, trig_address); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if ({busy, done, wrapped, in_ready, wr_write} !== 5'b0 || trig_address !== 2'd0 || sample_count !== 3'd0) begin errors++; $display("FAIL mid_reset got flags=%b trig=%0d cnt=%0d want 00000 0 0", {busy, done, wrapped, in_ready, wr_write}, trig_address, sample_count); end
      step();
      reset = 1'b0;
      base = wcnt;
      trigger = 1'b1;
      step(); step(); step();
      checks++; if (wcnt - base !== 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_idle got writes=%0d busy=%b want 0 0", wcnt - base, busy); end
      in_valid = 1'b0; trigger = 1'b0;
   endtask

   task automatic test_sop();
      int base;
      base = wcnt;
      do_arm(3'd0);
      in_valid = 1'b1; trigger = 1'b0; in_startofpacket = 1'b0; in_data = 8'h90;
      step();
      in_startofpacket = 1'b1; in_data = 8'h91;
      step();
      in_startofpacket = 1'b0;
`ifdef TRACESYS_CAPTURE_SOP_TRIGGER_EN
      in_valid = 1'b0;
      checks++; if (done !== 1'b1 || trig_address !== 2'd1) begin errors++; $display("FAIL sop_trig got done=%b trig=%0d want 1 1", done, trig_address); end
      step();
      checks++; if (wcnt - base !== 2) begin errors++; $display("FAIL sop_writes got %0d want 2", wcnt - base); end
`else
      checks++; if (done !== 1'b0 || busy !== 1'b1 || trig_address !== 2'd0) begin errors++; $display("FAIL sop_ignored got done=%b busy=%b trig=%0d want 0 1 0", done, busy, trig_address); end
      trigger = 1'b1; in_data = 8'h92;
      step();
      in_valid = 1'b0; trigger = 1'b0;
      checks++; if (done !== 1'b1 || trig_address !== 2'd2) begin errors++; $display("FAIL sop_plain got done=%b trig=%0d want 1 2", done, trig_address); end
      step();
      checks++; if (wcnt - base !== 3) begin errors++; $display("FAIL sop_writes got %0d want 3", wcnt - base); end
`endif
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_clamp();
      test_waitrequest();
      test_reset_mid();
      test_sop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
